// File: rtl/mmio_pkg.sv
// Shared types and I/O map for the memory-mapped data bus and its initiators.
package mmio_pkg;

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, FIN} dma_state_t;

  localparam logic [31:0] HEX_ADDR  = 32'h0000_0400;
  localparam logic [31:0] SW_ADDR   = 32'h0000_0404;
  localparam logic [31:0] BTNC_ADDR = 32'h0000_0408;
  localparam logic [31:0] BTNU_ADDR = 32'h0000_040C;
  localparam logic [31:0] BTNL_ADDR = 32'h0000_0410;
  localparam logic [31:0] BTNR_ADDR = 32'h0000_0414;
  localparam logic [31:0] BTND_ADDR = 32'h0000_0418;
  localparam logic [31:0] LED_ADDR  = 32'h0000_041C;

endpackage

// File: rtl/mmio_dma.sv
// Block-copy bus initiator: reads a word, writes it, repeats, sharing the
// CPU's data bus through a req/gnt handshake.
module mmio_dma
  import mmio_pkg::*;
#(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             memread,
  output logic             memwrite,
  output logic [31:0]      addr,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done
);

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  dma_state_t       state, nxt;
  logic [31:0]      src, dst, data;
  logic [LEN_W-1:0] remaining;
  logic             abort_pend;
  logic             accept;

  // Abort arriving together with start cancels the launch.
  assign accept = (state == IDLE) && start && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = (len == '0) ? FIN : REQ;
      REQ:  if (abort || abort_pend) nxt = FIN;
            else if (bus_gnt)        nxt = RD;
      RD:   if (bus_gnt) nxt = WR;
      WR:   if (bus_gnt) nxt = (remaining == LEN_W'(1) || abort || abort_pend) ? FIN : RD;
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src        <= '0;
      dst        <= '0;
      data       <= '0;
      remaining  <= '0;
      words_done <= '0;
      abort_pend <= 1'b0;
    end else begin
      if (accept) begin
        src        <= src_addr;
        dst        <= dst_addr;
        remaining  <= len;
        words_done <= '0;
        abort_pend <= 1'b0;
      end else if (state != IDLE && abort) begin
        abort_pend <= 1'b1;
      end
      if (state == RD && bus_gnt) data <= readdata;
      if (state == WR && bus_gnt) begin
        src        <= src + STEP;
        dst        <= dst + STEP;
        remaining  <= remaining - LEN_W'(1);
        words_done <= words_done + LEN_W'(1);
      end
    end
  end

  // Strobes and address are gated by grant so a lost grant idles the bus.
  always_comb begin
    bus_req   = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    addr      = '0;
    writedata = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      REQ: bus_req = 1'b1;
      RD: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          memread = 1'b1;
          addr    = src;
        end
      end
      WR: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          memwrite  = 1'b1;
          addr      = dst;
          writedata = data;
        end
      end
      FIN: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmio_dma.sv
// Directed bench for mmio_dma: word copies, zero length, grant loss, abort,
// async reset, address wrap and a switch-to-hex transfer with zero stride.
module tb_mmio_dma;
  import mmio_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0, bus_gnt = 1'b1;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] len = '0;
  logic        bus_req, memread, memwrite, busy, done;
  logic [31:0] addr, writedata, readdata;
  logic [15:0] words_done;

  logic        io_start = 1'b0, io_req, io_rd, io_wr, io_busy, io_done;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [15:0] io_wd;
  logic [31:0] sw = 32'h0000_BEEF, hex;

  logic [31:0] mem [0:1023];
  int n_rd = 0, n_wr = 0, n_viol = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mmio_dma #(.ADDR_STEP(4), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .abort(abort), .bus_req(bus_req), .bus_gnt(bus_gnt), .memread(memread),
    .memwrite(memwrite), .addr(addr), .writedata(writedata), .readdata(readdata),
    .busy(busy), .done(done), .words_done(words_done));

  mmio_dma #(.ADDR_STEP(0), .LEN_W(16)) dut_io (
    .clk(clk), .reset(reset), .start(io_start), .src_addr(SW_ADDR), .dst_addr(HEX_ADDR),
    .len(16'd1), .abort(1'b0), .bus_req(io_req), .bus_gnt(1'b1), .memread(io_rd),
    .memwrite(io_wr), .addr(io_addr), .writedata(io_wdata), .readdata(io_rdata),
    .busy(io_busy), .done(io_done), .words_done(io_wd));

  // Source region is a fixed pattern: 0x10 -> 0xA0, 0x14 -> 0xA1, ...
  assign readdata = 32'hA0 + {20'h0, addr[11:2]} - 32'd4;
  assign io_rdata = (io_addr == SW_ADDR) ? sw : 32'h0;

  always @(posedge clk) begin
    if (memread)  n_rd <= n_rd + 1;
    if (memwrite) begin
      n_wr <= n_wr + 1;
      mem[addr[11:2]] <= writedata;
    end
    if ((memread && memwrite) || (!memread && !memwrite && addr != 0) ||
        (!bus_gnt && (memread || memwrite)))
      n_viol <= n_viol + 1;
  end

  always @(posedge clk or posedge reset)
    if (reset) hex <= '0;
    else if (io_wr && io_addr == HEX_ADDR) hex <= io_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                      input logic ab);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; len = l; start = 1'b1; abort = ab; bus_gnt = 1'b1;
  endtask

  // Cycle k=1 is the first cycle after the edge that samples start.
  task automatic run(input int budget, input int abort_k, input bit toggle,
                     output int done_k, output int ndone, output int nbusy, output int rd_k);
    done_k = 0; ndone = 0; nbusy = 0; rd_k = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      abort   = (k == abort_k);
      bus_gnt = toggle ? ((k % 6) < 3) : 1'b1;
      #1;
      if (done) begin ndone++; if (done_k == 0) done_k = k; end
      if (busy) nbusy++;
      if (memread && rd_k == 0) rd_k = k;
    end
    abort = 1'b0; bus_gnt = 1'b1;
  endtask

  int dk, nd, nb, rk, r0, w0, v0;

  initial begin
    #12;
    chk("rst_ctl", {27'h0, bus_req, memread, memwrite, busy, done}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_wd", 32'(words_done), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Basic 4-word copy
    r0 = n_rd; w0 = n_wr; v0 = n_viol;
    kick(32'h10, 32'h40, 16'd4, 1'b0);
    run(20, 0, 0, dk, nd, nb, rk);
    chk("cp_first_rd", rk, 2);
    chk("cp_done_k", dk, 10);
    chk("cp_ndone", nd, 1);
    chk("cp_busy", nb, 10);
    chk("cp_rd", n_rd - r0, 4);
    chk("cp_wr", n_wr - w0, 4);
    chk("cp_viol", n_viol - v0, 0);
    for (int i = 0; i < 4; i++) chk("cp_data", mem[16 + i], 32'hA0 + 32'(i));
    chk("cp_wdone", 32'(words_done), 4);

    // Zero length
    r0 = n_rd; w0 = n_wr;
    kick(32'h10, 32'h80, 16'd0, 1'b0);
    run(8, 0, 0, dk, nd, nb, rk);
    chk("z_done_k", dk, 1);
    chk("z_busy", nb, 1);
    chk("z_strobes", (n_rd - r0) + (n_wr - w0), 0);
    chk("z_wdone", 32'(words_done), 0);

    // Grant toggling
    r0 = n_rd; w0 = n_wr; v0 = n_viol;
    kick(32'h10, 32'h80, 16'd3, 1'b0);
    run(40, 0, 1, dk, nd, nb, rk);
    chk("g_ndone", nd, 1);
    chk("g_wr", n_wr - w0, 3);
    chk("g_rd", n_rd - r0, 3);
    chk("g_viol", n_viol - v0, 0);
    for (int i = 0; i < 3; i++) chk("g_data", mem[32 + i], 32'hA0 + 32'(i));

    // Abort during the third read
    r0 = n_rd; w0 = n_wr;
    kick(32'h10, 32'hC0, 16'd10, 1'b0);
    run(30, 6, 0, dk, nd, nb, rk);
    chk("ab_done_k", dk, 8);
    chk("ab_ndone", nd, 1);
    chk("ab_wr", n_wr - w0, 3);
    chk("ab_rd", n_rd - r0, 3);
    chk("ab_wdone", 32'(words_done), 3);
    chk("ab_data", mem[50], 32'hA2);

    // Abort while requesting
    r0 = n_rd; w0 = n_wr;
    kick(32'h10, 32'h140, 16'd5, 1'b0);
    run(10, 1, 0, dk, nd, nb, rk);
    chk("abq_done_k", dk, 2);
    chk("abq_strobes", (n_rd - r0) + (n_wr - w0), 0);

    // Start together with abort in IDLE is ignored
    kick(32'h10, 32'h140, 16'd5, 1'b1);
    run(10, 0, 0, dk, nd, nb, rk);
    chk("sa_ndone", nd, 0);
    chk("sa_busy", nb, 0);

    // Destination wraps past the top of the address space
    kick(32'h10, 32'hFFFF_FFFC, 16'd2, 1'b0);
    run(12, 0, 0, dk, nd, nb, rk);
    chk("wrap_done_k", dk, 6);
    chk("wrap_hi", mem[1023], 32'hA0);
    chk("wrap_lo", mem[0], 32'hA1);

    // Async reset during the second word's write
    w0 = n_wr;
    kick(32'h10, 32'h200, 16'd4, 1'b0);
    for (int k = 1; k <= 5; k++) begin @(posedge clk); #1; start = 1'b0; end
    chk("rs_pre_wr", {31'h0, memwrite}, 32'h1);
    chk("rs_pre_addr", addr, 32'h204);
    #1 reset = 1'b1;
    #1;
    chk("rs_ctl", {27'h0, bus_req, memread, memwrite, busy, done}, 32'h0);
    chk("rs_addr", addr | writedata, 32'h0);
    chk("rs_wdone", 32'(words_done), 32'h0);
    #2 reset = 1'b0;
    run(15, 0, 0, dk, nd, nb, rk);
    chk("rs_ndone", nd, 0);
    chk("rs_wr", n_wr - w0, 1);
    kick(32'h10, 32'h100, 16'd2, 1'b0);
    run(12, 0, 0, dk, nd, nb, rk);
    chk("rs_again_k", dk, 6);
    chk("rs_again_d", mem[65], 32'hA1);
    chk("rs_again_wd", 32'(words_done), 2);

    // Switch register to hex display, zero stride
    @(posedge clk); #1 io_start = 1'b1;
    @(posedge clk); #1 io_start = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (io_done) nd++;
      @(posedge clk); #1;
    end
    chk("io_ndone", nd, 1);
    chk("io_hex", hex, 32'h0000_BEEF);
    chk("io_wdone", 32'(io_wd), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
